dsconv_block_depthwise_window_generator: RTL and testbench
==========================================================

Name: dsconv_block_depthwise_window_generator

Overview:
Streaming 7x7 sliding-window generator. It sits directly upstream of the depthwise processing element (49-tap, 18-bit signed, fully pipelined, one window per cycle). It accepts one raster-order pixel per valid cycle, buffers 6 prior rows in line buffers, and presents 49 window taps with a start strobe. Stride 1, valid-only windows; zero padding, if needed, is inserted upstream.

Parameters:
DATA_W, 18, pixel width, signed two's complement (fixed-point format passed through untouched)
IMG_W, 32, frame width in pixels, must be >= 7
IMG_H, 32, frame height in pixels, must be >= 7
K, 7, kernel size, fixed at 7; any other value is unsupported

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_pixel valid this cycle; no backpressure, every valid pixel is accepted
in_pixel  input  DATA_W  signed pixel, raster order (row-major, top-left first)
window_out  output  49*DATA_W  tap k at bits [DATA_W*k +: DATA_W]; k = r*7+c; tap 0 top-left (oldest), tap 48 bottom-right (newest pixel)
window_valid  output  1  one-cycle pulse; drives the PE start
out_row  output  clog2(IMG_H)  row of window top-left (input row - 6)
out_col  output  clog2(IMG_W)  column of window top-left (input col - 6)
frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset values: window_out=0, window_valid=0, out_row=0, out_col=0, frame_done=0. Counters and FSM go to col=0, row=0, S_FILL. Line-buffer RAM contents are not reset; the row gating makes stale data unobservable.
- Storage:
  - 6 line buffers, depth IMG_W, chained: the oldest row feeds tap row 0 and the current pixel feeds tap row 6.
  - 7x7 register window. On each accepted pixel, every row shifts left one column. Column 6 loads {lb5[col], lb4[col], ..., lb0[col], in_pixel}.
- Cycles with in_valid=0: nothing changes (counters, line buffers, window and outputs hold), except window_valid and frame_done, which drop to 0.
- Counters:
  - col increments per accepted pixel and wraps at IMG_W-1 to 0; on wrap, row increments.
  - When the pixel at (IMG_H-1, IMG_W-1) is accepted, row wraps to 0 and frame_done pulses the next cycle.
- FSM:
  - S_FILL (row 0..5): no windows. Moves to S_RUN when the last pixel of row 5 is accepted.
  - S_RUN (row 6..IMG_H-1): window_valid pulses the cycle after accepting a pixel with col >= 6. Returns to S_FILL on frame wrap.
- Latency: a pixel accepted at cycle t with (row >= 6, col >= 6) gives window_valid=1 at t+1. At that point window_out holds the 7x7 block with that pixel at tap 48, and out_row/out_col = row-6/col-6.
- Throughput: a continuous stream yields (IMG_H-6)*(IMG_W-6) windows per frame.
- Data path: window_out, out_row and out_col hold their last values between pulses.
- Arithmetic: no arithmetic on pixel data; bit-exact pass-through with sign preserved.
- Row boundary: windows never straddle rows. Columns 0..5 of each row only prime the window and produce no pulse.
- Back-to-back frames: the first pixel of the next frame may be accepted the cycle after the last pixel. frame_done and window_valid for the final window of the previous frame occur in the same cycle.
- Reset mid-frame: counters and FSM are cleared immediately and pending pulses are suppressed. The next accepted pixel is treated as (0,0); no window mixes pre-reset data.

Test Plan:
1. Assert rst for 3 cycles with in_valid toggling -> all outputs 0; no window_valid or frame_done.
2. IMG_W=IMG_H=8, pixel=r*8+c, continuous stream:
   - window_valid pulses exactly 4 times; the first pulse comes 1 cycle after pixel 54 is accepted.
   - At the first pulse, tap k = (k/7)*8 + k%7 (tap0=0, tap48=54).
   - Last window: out_row=1, out_col=1, tap0=9, tap48=63.
   - frame_done pulses once, 1 cycle after pixel 63.
3. Same frame with in_valid=1 only every other cycle -> identical 4 windows and coordinates; pulses are never wider than 1 cycle.
4. Two back-to-back frames, second with pixel=100+r*8+c -> 8 windows total; the first window of frame 2 has tap0=100, tap48=154; no tap from frame 1.
5. Reset asserted after pixel 58 of frame 1, then a fresh frame -> no windows from the aborted frame; the first pulse is 1 cycle after fresh pixel 54, with taps matching scenario 2.
6. pixel=-(r*8+c) -> first window tap48=18'h3FFCA (-54), tap0=0; all taps sign-exact.

Source files
------------

// File: rtl/dsconv_block_depthwise_window_generator.sv
// 7x7 sliding-window generator for the depthwise PE.
// Accepts one raster-order pixel per valid cycle, keeps the six previous rows
// in chained line buffers and presents a full 7x7 window with a one-cycle
// start strobe for every valid (non-padded, stride-1) window position.
//
// Handshake: in_valid qualifies in_pixel for one cycle; there is no ready,
// every valid pixel is consumed. window_valid and frame_done are one-cycle
// pulses registered the cycle after the pixel that caused them; window_out,
// out_row and out_col hold between pulses.
module dsconv_block_depthwise_window_generator #(
    parameter int DATA_W = 18,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int K      = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_pixel,
    output logic [K*K*DATA_W-1:0]       window_out,
    output logic                        window_valid,
    output logic [$clog2(IMG_H)-1:0]    out_row,
    output logic [$clog2(IMG_W)-1:0]    out_col,
    output logic                        frame_done,
    output logic [1:0]                  dbg_state
);

    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int NLB = K - 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_WIN   = CW'(K - 1);
    localparam logic [CW-1:0] COL_ONE   = CW'(1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_PRIME = RW'(K - 2);
    localparam logic [RW-1:0] ROW_WIN   = RW'(K - 1);
    localparam logic [RW-1:0] ROW_ONE   = RW'(1);

    // S_FILL: rows 0..K-2 are only being buffered, no window can be complete.
    // S_RUN : rows K-1..IMG_H-1, windows are emitted from column K-1 onward.
    localparam logic [1:0] S_FILL = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic              r_window_valid;
    logic              r_frame_done;
    logic [RW-1:0]     r_out_row;
    logic [CW-1:0]     r_out_col;

    // Line buffers are plain storage without reset: the FSM only emits windows
    // once all six rows of the current frame have been rewritten.
    logic [DATA_W-1:0] r_lb  [NLB][IMG_W];
    logic [DATA_W-1:0] r_win [K][K];

    logic              w_accept;
    logic              w_last_col;
    logic              w_last_row;
    logic              w_emit;
    logic [DATA_W-1:0] w_col_in [K];

    assign w_accept   = in_valid && !rst;
    assign w_last_col = (r_col == COL_LAST);
    assign w_last_row = (r_row == ROW_LAST);
    assign w_emit     = (r_state == S_RUN) && (r_col >= COL_WIN);

    // Column entering the window: oldest buffered row on top, live pixel at the bottom.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            w_col_in[i] = '0;
        end
        w_col_in[K-1] = in_pixel;
        for (int i = 0; i < NLB; i++) begin
            w_col_in[NLB-1-i] = r_lb[i][r_col];
        end
    end

    // Line-buffer chain: lb0 holds the previous row, each buffer passes its
    // entry one row older into the next buffer at the same column.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb[0][r_col] <= in_pixel;
            for (int i = 1; i < NLB; i++) begin
                r_lb[i][r_col] <= r_lb[i-1][r_col];
            end
        end
    end

    // 7x7 window register: shift every row left, load the new column at the right.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (in_valid) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][K-1] <= w_col_in[r];
            end
        end
    end

    // Raster counters, fill/run FSM and the registered output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_FILL;
            r_col          <= '0;
            r_row          <= '0;
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            r_out_row      <= '0;
            r_out_col      <= '0;
        end else if (in_valid) begin
            r_window_valid <= w_emit;
            r_frame_done   <= w_last_col && w_last_row;

            if (w_emit) begin
                r_out_row <= r_row - ROW_WIN;
                r_out_col <= r_col - COL_WIN;
            end

            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : (r_row + ROW_ONE);
            end else begin
                r_col <= r_col + COL_ONE;
            end

            case (r_state)
                S_FILL: begin
                    if (w_last_col && (r_row == ROW_PRIME)) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_last_col && w_last_row) begin
                        r_state <= S_FILL;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end else begin
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
        end
    end

    // Flatten the window: tap k = r*K + c, tap 0 top-left (oldest).
    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
            assign window_out[DATA_W*(r*K+c) +: DATA_W] = r_win[r][c];
        end
    end

    assign window_valid = r_window_valid;
    assign frame_done   = r_frame_done;
    assign out_row      = r_out_row;
    assign out_col      = r_out_col;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_dsconv_block_depthwise_window_generator.sv
// Bench for the 7x7 window generator on an 8x8 frame.
// Reference: an image array of the current frame; each window is cut
// directly out of that image by coordinates when its newest pixel arrives.
module tb_dsconv_block_depthwise_window_generator;

    localparam int DW = 18;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int K  = 7;
    localparam int WW = K * K * DW;

    // ---------------- clock / reset ----------------
    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic [DW-1:0]          in_pixel = '0;
    logic [WW-1:0]          window_out;
    logic                   window_valid;
    logic [$clog2(H)-1:0]   out_row;
    logic [$clog2(W)-1:0]   out_col;
    logic                   frame_done;
    logic [1:0]             dbg_state;

    always #5 clk = ~clk;

    dsconv_block_depthwise_window_generator #(
        .DATA_W(DW), .IMG_W(W), .IMG_H(H), .K(K)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel),
        .window_out(window_out), .window_valid(window_valid),
        .out_row(out_row), .out_col(out_col),
        .frame_done(frame_done), .dbg_state(dbg_state)
    );

    // ---------------- model / scoreboard state ----------------
    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] m_img [H][W];
    int            m_row = 0;
    int            m_col = 0;
    logic [WW-1:0] exp_q[$];
    int            exp_row_q[$];
    int            exp_col_q[$];
    logic          exp_wv = 1'b0;
    logic          exp_fd = 1'b0;
    bit            chk_en = 1'b0;
    int            acc_cnt = 0;

    logic [WW-1:0] cap_win[$];
    int            cap_row[$];
    int            cap_col[$];
    int            cap_acc[$];
    int            fd_acc[$];

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] tap(input logic [WW-1:0] w, input int k);
        return w[DW*k +: DW];
    endfunction

    // Record the pixel in the frame image; if it completes a window, cut that
    // window out of the image and queue it with its top-left coordinates.
    task automatic model_accept(input logic v, input logic [DW-1:0] p,
                                output logic nwv, output logic nfd);
        logic [WW-1:0] w;
        nwv = 1'b0;
        nfd = 1'b0;
        if (v) begin
            m_img[m_row][m_col] = p;
            if (m_row >= K - 1 && m_col >= K - 1) begin
                nwv = 1'b1;
                w = '0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        w[DW*(i*K+j) +: DW] = m_img[m_row-(K-1)+i][m_col-(K-1)+j];
                exp_q.push_back(w);
                exp_row_q.push_back(m_row - (K - 1));
                exp_col_q.push_back(m_col - (K - 1));
            end
            nfd = (m_row == H - 1) && (m_col == W - 1);
            if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic [DW-1:0] p);
        logic nwv, nfd;
        in_valid = v;
        in_pixel = p;
        model_accept(v, p, nwv, nfd);
        @(posedge clk);
        if (v) acc_cnt++;
        #1;
        exp_wv = nwv;
        exp_fd = nfd;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_valid = i[0];
            in_pixel = 18'h2AAAA;
            @(posedge clk);
            #1;
            exp_wv = 1'b0;
            exp_fd = 1'b0;
        end
        rst = 1'b0;
        in_valid = 1'b0;
        m_row = 0;
        m_col = 0;
        exp_q.delete();
        exp_row_q.delete();
        exp_col_q.delete();
    endtask

    task automatic send_pixels(input int base, input bit neg, input bit gap, input int npix);
        int v;
        for (int k = 0; k < npix; k++) begin
            v = base + k;
            step(1'b1, neg ? DW'(-v) : DW'(v));
            if (gap) step(1'b0, 18'h15555);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    task automatic clear_caps();
        cap_win.delete();
        cap_row.delete();
        cap_col.delete();
        cap_acc.delete();
        fd_acc.delete();
        acc_cnt = 0;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin : compare
        logic [WW-1:0] ew;
        int er, ec;
        if (chk_en) begin
            check("window_valid", window_valid, exp_wv);
            check("frame_done", frame_done, exp_fd);
            if (window_valid === 1'b1) begin
                cap_win.push_back(window_out);
                cap_row.push_back(out_row);
                cap_col.push_back(out_col);
                cap_acc.push_back(acc_cnt);
            end
            if (frame_done === 1'b1) fd_acc.push_back(acc_cnt);
            if (exp_wv) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL exp_queue: got empty expected an entry");
                end else begin
                    ew = exp_q.pop_front();
                    er = exp_row_q.pop_front();
                    ec = exp_col_q.pop_front();
                    check("window_out", window_out, ew);
                    check("out_row", out_row, er);
                    check("out_col", out_col, ec);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    int er3 [4] = '{0, 0, 1, 1};
    int ec3 [4] = '{0, 1, 0, 1};
    int et3 [4] = '{0, 1, 8, 9};

    initial begin
        // 1: reset with in_valid toggling
        do_reset(3);
        check("rst_window_out", window_out, '0);
        check("rst_window_valid", window_valid, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_out_row", out_row, '0);
        check("rst_out_col", out_col, '0);
        chk_en = 1'b1;

        // 2: continuous frame, pixel = r*8+c
        clear_caps();
        send_pixels(0, 1'b0, 1'b0, W * H);
        idle(3);
        check("s2_windows", cap_win.size(), 4);
        check("s2_frame_done_cnt", fd_acc.size(), 1);
        if (fd_acc.size() >= 1) check("s2_frame_done_at", fd_acc[0], 64);
        if (cap_win.size() >= 4) begin
            check("s2_first_at", cap_acc[0], 55);
            for (int k = 0; k < K * K; k++)
                check("s2_first_tap", tap(cap_win[0], k), (k / 7) * 8 + k % 7);
            check("s2_last_row", cap_row[3], 1);
            check("s2_last_col", cap_col[3], 1);
            check("s2_last_tap0", tap(cap_win[3], 0), 9);
            check("s2_last_tap48", tap(cap_win[3], 48), 63);
        end

        // 3: same frame with a gap cycle after every pixel
        clear_caps();
        send_pixels(0, 1'b0, 1'b1, W * H);
        idle(3);
        check("s3_windows", cap_win.size(), 4);
        if (cap_win.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("s3_row", cap_row[i], er3[i]);
                check("s3_col", cap_col[i], ec3[i]);
                check("s3_tap0", tap(cap_win[i], 0), et3[i]);
            end
        end

        // 4: two back-to-back frames
        clear_caps();
        send_pixels(0, 1'b0, 1'b0, W * H);
        send_pixels(100, 1'b0, 1'b0, W * H);
        idle(3);
        check("s4_windows", cap_win.size(), 8);
        check("s4_frame_done_cnt", fd_acc.size(), 2);
        if (cap_win.size() >= 8) begin
            check("s4_f2_tap0", tap(cap_win[4], 0), 100);
            check("s4_f2_tap48", tap(cap_win[4], 48), 154);
        end

        // 5: reset after pixel 58, then a fresh frame
        clear_caps();
        send_pixels(0, 1'b0, 1'b0, 59);
        do_reset(3);
        clear_caps();
        send_pixels(0, 1'b0, 1'b0, W * H);
        idle(3);
        check("s5_windows", cap_win.size(), 4);
        if (cap_win.size() >= 4) begin
            check("s5_first_at", cap_acc[0], 55);
            check("s5_tap0", tap(cap_win[0], 0), 0);
            check("s5_tap48", tap(cap_win[0], 48), 54);
        end

        // 6: negative pixels
        clear_caps();
        send_pixels(0, 1'b1, 1'b0, W * H);
        idle(3);
        check("s6_windows", cap_win.size(), 4);
        if (cap_win.size() >= 1) begin
            check("s6_tap48", tap(cap_win[0], 48), 18'h3FFCA);
            check("s6_tap0", tap(cap_win[0], 0), 0);
            check("s6_tap48_signed", ($signed(tap(cap_win[0], 48)) == -54), 1'b1);
            check("s6_tap8", tap(cap_win[0], 8), 18'h3FFF7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
